// File: rtl/inv_key_expansion_256.sv
// Reverse AES-256 key schedule: loaded with round keys 13/14,
// emits round keys 14 down to 0 over a valid/ready handshake.

module inv_key_expansion_256_sbox (
  input  logic [7:0] i_in,
  input  logic       i_inv_en,
  output logic [7:0] o_out
);

  function automatic logic [7:0] gmul(
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [7:0] p;
    logic [7:0] x;
    logic [7:0] y;
    p = 8'h00;
    x = a;
    y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b)
               : {x[6:0], 1'b0};
      y = {1'b0, y[7:1]};
    end
    return p;
  endfunction

  // a^254 is the GF(2^8) inverse; 0 maps to 0
  function automatic logic [7:0] ginv(
    input logic [7:0] a
  );
    logic [7:0] r;
    r = 8'h01;
    for (int i = 7; i >= 0; i--) begin
      r = gmul(r, r);
      if (i != 0) r = gmul(r, a);
    end
    return r;
  endfunction

  logic [7:0] w_aff;
  logic [7:0] w_g;

  assign w_aff = {i_in[6:0], i_in[7]}
               ^ {i_in[4:0], i_in[7:5]}
               ^ {i_in[1:0], i_in[7:2]}
               ^ 8'h05;

  assign w_g = ginv(i_inv_en ? w_aff : i_in);

  // forward affine map, or plain inverse for InvSubBytes
  always_comb begin
    o_out = w_g;
    if (!i_inv_en) begin
      o_out = w_g
            ^ {w_g[6:0], w_g[7]}
            ^ {w_g[5:0], w_g[7:6]}
            ^ {w_g[4:0], w_g[7:5]}
            ^ {w_g[3:0], w_g[7:4]}
            ^ 8'h63;
    end
  end

endmodule

module inv_key_expansion_256 #(
  parameter int KEY_WIDTH = 256
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [KEY_WIDTH-1:0] key_last,
  output logic [127:0]         rk_o,
  output logic [3:0]           rk_round,
  output logic                 rk_valid,
  input  logic                 rk_ready,
  output logic                 rk_last,
  output logic                 busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_EMIT_HI,
    S_EMIT_LO,
    S_SUB,
    S_MIX,
    S_EMIT
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [KEY_WIDTH-1:0] r_w;
  logic [3:0]           r_k;
  logic [1:0]           r_cnt;
  logic [31:0]          r_t;
  logic [127:0]         r_rk;
  logic [3:0]           r_rnd;
  logic                 r_valid;
  logic                 r_last;

  logic        w_acc;
  logic [31:0] w_w3;
  logic [31:0] w_w4;
  logic [31:0] w_w5;
  logic [31:0] w_w6;
  logic [31:0] w_w7;
  logic [31:0] w_src;
  logic [7:0]  w_sb_in;
  logic [7:0]  w_sb_out;
  logic [31:0] w_rc;
  logic [31:0] w_n0;
  logic [31:0] w_n1;
  logic [31:0] w_n2;
  logic [31:0] w_n3;

  assign w_acc = r_valid & rk_ready;

  assign w_w3 = r_w[159:128];
  assign w_w4 = r_w[127:96];
  assign w_w5 = r_w[95:64];
  assign w_w6 = r_w[63:32];
  assign w_w7 = r_w[31:0];

  // odd k means word 4k+4 sits on an 8-word boundary
  assign w_src = r_k[0] ? {w_w3[23:0], w_w3[31:24]}
                        : w_w3;

  assign w_rc = r_k[0] ? {8'h01 << r_k[3:1], 24'h0}
                       : 32'h0;

  assign w_n3 = w_w7 ^ w_w6;
  assign w_n2 = w_w6 ^ w_w5;
  assign w_n1 = w_w5 ^ w_w4;
  assign w_n0 = w_w4 ^ r_t ^ w_rc;

  // pick the S-box byte for this SUB cycle, MSB first
  always_comb begin
    w_sb_in = w_src[31:24];
    case (r_cnt)
      2'd0: w_sb_in = w_src[31:24];
      2'd1: w_sb_in = w_src[23:16];
      2'd2: w_sb_in = w_src[15:8];
      2'd3: w_sb_in = w_src[7:0];
      default: w_sb_in = w_src[31:24];
    endcase
  end

  inv_key_expansion_256_sbox u_sbox (
    .i_in     (w_sb_in),
    .i_inv_en (1'b0),
    .o_out    (w_sb_out)
  );

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // next-state logic
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:    if (start) w_next = S_EMIT_HI;
      S_EMIT_HI: if (w_acc) w_next = S_EMIT_LO;
      S_EMIT_LO: if (w_acc) w_next = S_SUB;
      S_SUB:     if (r_cnt == 2'd3) w_next = S_MIX;
      S_MIX:     w_next = S_EMIT;
      S_EMIT: begin
        if (w_acc)
          w_next = (r_k == 4'd0) ? S_IDLE : S_SUB;
      end
      default:   w_next = S_IDLE;
    endcase
  end

  // key window, counters and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_w     <= '0;
      r_k     <= 4'd0;
      r_cnt   <= 2'd0;
      r_t     <= 32'h0;
      r_rk    <= 128'h0;
      r_rnd   <= 4'd0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_w     <= key_last;
            r_k     <= 4'd13;
            r_rk    <= key_last[127:0];
            r_rnd   <= 4'd14;
            r_valid <= 1'b1;
            r_last  <= 1'b0;
          end
        end
        S_EMIT_HI: begin
          if (w_acc) begin
            r_rk  <= r_w[255:128];
            r_rnd <= 4'd13;
          end
        end
        S_EMIT_LO: begin
          if (w_acc) begin
            r_valid <= 1'b0;
            r_cnt   <= 2'd0;
          end
        end
        S_SUB: begin
          case (r_cnt)
            2'd0: r_t[31:24] <= w_sb_out;
            2'd1: r_t[23:16] <= w_sb_out;
            2'd2: r_t[15:8]  <= w_sb_out;
            2'd3: r_t[7:0]   <= w_sb_out;
            default: r_t[7:0] <= w_sb_out;
          endcase
          r_cnt <= r_cnt + 2'd1;
        end
        S_MIX: begin
          r_w     <= {w_n0, w_n1, w_n2, w_n3,
                      r_w[255:128]};
          r_k     <= r_k - 4'd1;
          r_rk    <= {w_n0, w_n1, w_n2, w_n3};
          r_rnd   <= r_k - 4'd1;
          r_valid <= 1'b1;
          r_last  <= (r_k == 4'd1);
        end
        S_EMIT: begin
          if (w_acc) begin
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_cnt   <= 2'd0;
          end
        end
        default: ;
      endcase
    end
  end

  assign rk_o     = r_rk;
  assign rk_round = r_rnd;
  assign rk_valid = r_valid;
  assign rk_last  = r_last;
  assign busy     = (r_state != S_IDLE);

endmodule

// File: tb/tb_inv_key_expansion_256.sv
// Scoreboard bench: forward AES-256 expansion model predicts
// the backward key stream; a monitor checks each handshake.

module tb_inv_key_expansion_256;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [255:0] key_last;
  logic [127:0] rk_o;
  logic [3:0]   rk_round;
  logic         rk_valid;
  logic         rk_ready;
  logic         rk_last;
  logic         busy;

  inv_key_expansion_256 #(.KEY_WIDTH(256)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .key_last (key_last),
    .rk_o     (rk_o),
    .rk_round (rk_round),
    .rk_valid (rk_valid),
    .rk_ready (rk_ready),
    .rk_last  (rk_last),
    .busy     (busy)
  );

  typedef struct {
    logic [127:0] key;
    logic [3:0]   rnd;
    logic         last;
  } exp_t;

  exp_t q[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int t14 = 0;
  int t_done = 0;
  int done_cnt = 0;
  int last_acc = 15;
  bit rnd_mode = 0;
  bit fips_mode = 0;
  bit prev_stall = 0;
  logic [127:0] prev_key;
  logic [3:0]   prev_rnd;
  logic [31:0]  fw [60];

  localparam logic [255:0] FIPS_KEY =
    256'h000102030405060708090a0b0c0d0e0f_101112131415161718191a1b1c1d1e1f;
  localparam logic [255:0] FIPS_LAST =
    256'h4e5a6699a9f24fe07e572baacdf8cdea_24fc79ccbf0979e9371ac23c6d68de36;

  localparam logic [7:0] SBOX [256] = '{
    8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
    8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
    8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
    8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
    8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
    8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
    8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
    8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
    8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
    8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
    8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
    8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
    8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
    8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
    8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
    8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
  };

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    rk_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      rk_ready = rnd_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  end

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] x);
    return {SBOX[x[31:24]], SBOX[x[23:16]], SBOX[x[15:8]], SBOX[x[7:0]]};
  endfunction

  // forward FIPS-197 expansion of a 256-bit key into w[0..59]
  function automatic void expand(input logic [255:0] k);
    logic [31:0] t;
    for (int i = 0; i < 8; i++) fw[i] = k[255-32*i -: 32];
    for (int i = 8; i < 60; i++) begin
      t = fw[i-1];
      if (i % 8 == 0)
        t = subw({t[23:0], t[31:24]}) ^ {8'h01 << (i/8 - 1), 24'h0};
      else if (i % 8 == 4)
        t = subw(t);
      fw[i] = fw[i-8] ^ t;
    end
  endfunction

  function automatic bit fips_ref(input logic [3:0] r,
                                  output logic [127:0] v);
    v = '0;
    case (r)
      4'd14: v = 128'h24fc79ccbf0979e9371ac23c6d68de36;
      4'd13: v = 128'h4e5a6699a9f24fe07e572baacdf8cdea;
      4'd2:  v = 128'ha573c29fa176c498a97fce93a572c09c;
      4'd1:  v = 128'h101112131415161718191a1b1c1d1e1f;
      4'd0:  v = 128'h000102030405060708090a0b0c0d0e0f;
      default: return 1'b0;
    endcase
    return 1'b1;
  endfunction

  function automatic logic [255:0] rand256();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  // monitor: stall stability and scoreboard pop on handshake
  initial begin
    exp_t e;
    logic [127:0] fv;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          chk("stall_valid", 128'(rk_valid), 128'd1);
          chk("stall_key", rk_o, prev_key);
          chk("stall_round", 128'(rk_round), 128'(prev_rnd));
        end
        if (rk_valid && !prev_stall && rk_round == 4'd14) t14 = cyc;
        if (rk_valid && rk_ready) begin
          if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_key got round %0d want none", rk_round);
          end else begin
            e = q.pop_front();
            chk("key", rk_o, e.key);
            chk("round", 128'(rk_round), 128'(e.rnd));
            chk("last", 128'(rk_last), 128'(e.last));
            if (fips_mode && fips_ref(rk_round, fv))
              chk("fips_const", rk_o, fv);
          end
          last_acc = int'(rk_round);
          if (rk_round == 4'd0) begin
            t_done = cyc;
            done_cnt++;
          end
        end
        prev_stall = rk_valid && !rk_ready;
        prev_key = rk_o;
        prev_rnd = rk_round;
      end
    end
  end

  task automatic start_key(input logic [255:0] mk, input bit fips);
    exp_t e;
    expand(mk);
    for (int r = 14; r >= 0; r--) begin
      e.key  = {fw[4*r], fw[4*r+1], fw[4*r+2], fw[4*r+3]};
      e.rnd  = 4'(r);
      e.last = (r == 0);
      q.push_back(e);
    end
    fips_mode = fips;
    key_last = fips ? FIPS_LAST
                    : {fw[52], fw[53], fw[54], fw[55],
                       fw[56], fw[57], fw[58], fw[59]};
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("start_valid", 128'(rk_valid), 128'd1);
    chk("start_round", 128'(rk_round), 128'd14);
  endtask

  task automatic wait_done(input bit ready_held);
    int n0;
    int k;
    n0 = done_cnt;
    k = 0;
    while (done_cnt == n0 && k < 3000) begin
      @(posedge clk);
      k++;
    end
    if (done_cnt == n0) begin
      checks++;
      errors++;
      $display("FAIL done_timeout got %0d cycles want round 0", k);
    end else begin
      @(negedge clk);
      chk("busy_after", 128'(busy), 128'd0);
      chk("queue_empty", 128'(q.size()), 128'd0);
      if (ready_held)
        chk("cycles80", 128'(t_done - t14 + 1), 128'd80);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    rst_n = 1'b0;
    start = 1'b0;
    key_last = '0;
    repeat (3) @(negedge clk);
    chk("rst_rk_o", rk_o, 128'h0);
    chk("rst_round", 128'(rk_round), 128'd0);
    chk("rst_valid", 128'(rk_valid), 128'd0);
    chk("rst_last", 128'(rk_last), 128'd0);
    chk("rst_busy", 128'(busy), 128'd0);
    rst_n = 1'b1;
    @(negedge clk);

    rnd_mode = 1'b0;
    start_key(FIPS_KEY, 1'b1);
    wait_done(1'b1);

    start_key(rand256(), 1'b0);
    wait_done(1'b1);

    rnd_mode = 1'b1;
    start_key(FIPS_KEY, 1'b1);
    wait_done(1'b0);

    rnd_mode = 1'b0;
    start_key(FIPS_KEY, 1'b1);
    k = 0;
    while (!(rk_valid && rk_round == 4'd7) && k < 500) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("reach_round7", 128'(k < 500), 128'd1);
    key_last = ~FIPS_LAST;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("busy_ignore", 128'(busy), 128'd1);
    wait_done(1'b1);

    start_key(rand256(), 1'b0);
    k = 0;
    while (last_acc != 6 && k < 500) begin
      @(posedge clk);
      k++;
    end
    chk("reach_round6", 128'(k < 500), 128'd1);
    chk("busy_pre_rst", 128'(busy), 128'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_rk_o", rk_o, 128'h0);
    chk("mid_rst_round", 128'(rk_round), 128'd0);
    chk("mid_rst_valid", 128'(rk_valid), 128'd0);
    chk("mid_rst_last", 128'(rk_last), 128'd0);
    chk("mid_rst_busy", 128'(busy), 128'd0);
    q.delete();
    fips_mode = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("post_rst_valid", 128'(rk_valid), 128'd0);
    chk("post_rst_busy", 128'(busy), 128'd0);
    start_key(FIPS_KEY, 1'b1);
    wait_done(1'b1);

    for (int i = 0; i < 100; i++) begin
      rnd_mode = i[0];
      start_key(rand256(), 1'b0);
      wait_done(!rnd_mode);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
